n64_poll_ctrl: RTL and testbench
================================

N64_POLL_CTRL -- requirements
Module: n64_poll_ctrl

Interface
REQ-001 Parameter POLL_PERIOD, default 833333, cycles between automatic controller polls.
REQ-002 Parameter TIMEOUT_CYC, default 50000, cycles allowed from transaction issue to read completion.
REQ-003 Parameter POLL_CMD, default 8'h01, command byte used for automatic polls.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 host_req  in  1  host command request; held with host_cmd stable until host_ack.
REQ-007 host_cmd  in  8  host command byte.
REQ-008 host_ack  out  1  one-cycle pulse: host command granted.
REQ-009 wr_en  out  1  start request to command writer.
REQ-010 wr_cmd  out  8  command byte to writer; stable while wr_en high.
REQ-011 wr_busy  in  1  writer transmitting.
REQ-012 wr_done  in  1  writer finished, one-cycle pulse.
REQ-013 rd_start  out  1  one-cycle pulse starting the response reader.
REQ-014 rd_done  in  1  reader finished, one-cycle pulse.
REQ-015 rd_data  in  32  reader response word, valid with rd_done.
REQ-016 buttons  out  32  last poll response; buttons_valid  out  1  pulse on update.
REQ-017 resp_data  out  32  last host-command response; resp_valid  out  1  pulse on update.
REQ-018 timeout_err  out  1  one-cycle pulse on abandoned transaction; busy  out  1  state != IDLE.

Function
REQ-019 States: IDLE, ISSUE, WAIT_WR, WAIT_RD; one transaction in flight at most.
REQ-020 Period counter free-runs 0..POLL_PERIOD-1, wraps to 0; wrap sets poll_pending; an additional wrap while pending is dropped.
REQ-021 IDLE grant: host_req and poll_pending both set -> grant opposite of last grant; one set -> grant it; none -> stay.
REQ-022 Grant cycle: load wr_cmd (host_cmd or POLL_CMD), record owner, pulse host_ack if host, clear poll_pending if poll, go ISSUE.
REQ-023 ISSUE: wr_en=1; on wr_busy=1, wr_en=0 next cycle and go WAIT_WR.
REQ-024 wr_en SHALL be low in every state except ISSUE, so the writer never re-latches.
REQ-025 WAIT_WR: on wr_done, pulse rd_start next cycle and go WAIT_RD.
REQ-026 WAIT_RD: on rd_done, owner poll -> buttons<=rd_data, buttons_valid pulse; owner host -> resp_data<=rd_data, resp_valid pulse; go IDLE.
REQ-027 Timeout counter clears on grant, increments in non-IDLE states; reaching TIMEOUT_CYC -> timeout_err pulse, wr_en=0, IDLE; buttons/resp_data unchanged.
REQ-028 rd_done and timeout in same cycle: rd_done wins, no timeout_err.
REQ-029 Minimum one IDLE cycle between transactions.

Reset
REQ-030 rst_n low: state IDLE; all outputs 0, including wr_cmd, buttons, resp_data; counters 0; poll_pending 0; last grant = poll (host wins first tie).
REQ-031 Reset mid-transaction abandons it silently, no timeout_err.

Configuration
REQ-032 N64_POLL_RETRY_EN defined: a timed-out poll (not host) is reissued once immediately with a fresh timeout; timeout_err pulses only if the retry also times out.
REQ-033 N64_POLL_RETRY_EN undefined: every timeout pulses timeout_err and returns to IDLE; no retry logic present.

Structure
REQ-034 Shared package n64_pkg: state enum, N64_CMD_STATUS 8'h00, N64_CMD_POLL 8'h01, N64_CMD_RESET 8'hFF, response width 32.
REQ-035 One sub-module, n64_poll_timer, holds period counter and poll_pending; FSM and timeout in top.

Verification
REQ-036 POLL_PERIOD=100, writer/reader models return 32'h8000_1234 -> wr_cmd=8'h01 every 100 cycles, buttons=32'h8000_1234, buttons_valid pulse per poll.
REQ-037 host_req with 8'h00 and poll_pending in same IDLE cycle after reset -> host_ack first, resp_valid then buttons_valid; next tie grants poll.
REQ-038 Reader never returns rd_done, TIMEOUT_CYC=50 -> timeout_err 50 cycles after grant, busy=0, buttons unchanged (retry off).
REQ-039 N64_POLL_RETRY_EN, first poll times out, second returns 32'hA5A5_0000 -> no timeout_err, buttons=32'hA5A5_0000.
REQ-040 rst_n low during WAIT_RD then high -> all outputs 0, no rd_start/timeout_err, next poll starts POLL_PERIOD cycles after reset release.

Source files
------------

// File: rtl/n64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : n64_pkg
// Description : Shared types and command constants for the N64 poll controller.
// Revision    : 1.0 - initial release
// ============================================================================
package n64_pkg;

    localparam logic [7:0] N64_CMD_STATUS = 8'h00;
    localparam logic [7:0] N64_CMD_POLL   = 8'h01;
    localparam logic [7:0] N64_CMD_RESET  = 8'hFF;
    localparam int         N64_RESP_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_WR = 2'd2,
        ST_WAIT_RD = 2'd3
    } n64_state_t;

    typedef enum logic {
        OWN_POLL = 1'b0,
        OWN_HOST = 1'b1
    } n64_owner_t;

endpackage : n64_pkg
`default_nettype wire

// File: rtl/n64_poll_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : n64_poll_ctrl_if
// Description : Host, writer, reader and result signals of the poll controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface n64_poll_ctrl_if;
    import n64_pkg::*;

    logic                  host_req;
    logic [7:0]            host_cmd;
    logic                  host_ack;
    logic                  wr_en;
    logic [7:0]            wr_cmd;
    logic                  wr_busy;
    logic                  wr_done;
    logic                  rd_start;
    logic                  rd_done;
    logic [N64_RESP_W-1:0] rd_data;
    logic [N64_RESP_W-1:0] buttons;
    logic                  buttons_valid;
    logic [N64_RESP_W-1:0] resp_data;
    logic                  resp_valid;
    logic                  timeout_err;
    logic                  busy;

    modport master (
        input  host_req, host_cmd, wr_busy, wr_done, rd_done, rd_data,
        output host_ack, wr_en, wr_cmd, rd_start, buttons, buttons_valid,
               resp_data, resp_valid, timeout_err, busy
    );

    modport slave (
        output host_req, host_cmd, wr_busy, wr_done, rd_done, rd_data,
        input  host_ack, wr_en, wr_cmd, rd_start, buttons, buttons_valid,
               resp_data, resp_valid, timeout_err, busy
    );

endinterface : n64_poll_ctrl_if
`default_nettype wire

// File: rtl/n64_poll_timer.sv
`default_nettype none
// ============================================================================
// Module      : n64_poll_timer
// Description : Free-running poll period counter with a sticky poll_pending flag.
// Revision    : 1.0 - initial release
// ============================================================================
module n64_poll_timer #(
    parameter int POLL_PERIOD = 833333
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clear,
    output logic      o_pending
);

    localparam int CNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             w_wrap;

    always_comb begin
        w_wrap    = (cnt_q == CNT_W'(POLL_PERIOD - 1));
        cnt_d     = w_wrap ? '0 : cnt_q + 1'b1;
        pending_d = pending_q;
        if (i_clear) pending_d = 1'b0;
        // A wrap coinciding with a clear starts a fresh pending period.
        if (w_wrap)  pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign o_pending = pending_q;

endmodule : n64_poll_timer
`default_nettype wire

// File: rtl/n64_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : n64_poll_ctrl
// Description : Arbitrates periodic polls and host commands onto one N64 link;
//               N64_POLL_RETRY_EN adds a single reissue of a timed-out poll.
// Revision    : 1.0 - initial release
// ============================================================================
module n64_poll_ctrl
    import n64_pkg::*;
#(
    parameter int         POLL_PERIOD = 833333,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] POLL_CMD    = 8'h01
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    n64_poll_ctrl_if.master   bus
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    n64_state_t            state_q, state_d;
    n64_owner_t            owner_q, owner_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [7:0]            wr_cmd_q, wr_cmd_d;
    logic                  wr_en_q, wr_en_d;
    logic                  host_ack_q, host_ack_d;
    logic                  rd_start_q, rd_start_d;
    logic [N64_RESP_W-1:0] buttons_q, buttons_d;
    logic                  buttons_valid_q, buttons_valid_d;
    logic [N64_RESP_W-1:0] resp_data_q, resp_data_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  timeout_err_q, timeout_err_d;
`ifdef N64_POLL_RETRY_EN
    logic                  retry_q, retry_d;
`endif

    logic w_poll_pending, w_poll_clear;
    logic w_grant_host, w_grant_poll, w_tmo_hit;

    n64_poll_timer #(.POLL_PERIOD(POLL_PERIOD)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_poll_clear),
        .o_pending (w_poll_pending)
    );

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        tmo_d           = tmo_q;
        wr_cmd_d        = wr_cmd_q;
        wr_en_d         = 1'b0;
        host_ack_d      = 1'b0;
        rd_start_d      = 1'b0;
        buttons_d       = buttons_q;
        buttons_valid_d = 1'b0;
        resp_data_d     = resp_data_q;
        resp_valid_d    = 1'b0;
        timeout_err_d   = 1'b0;
        w_poll_clear    = 1'b0;
`ifdef N64_POLL_RETRY_EN
        retry_d         = retry_q;
`endif
        // owner_q doubles as the last grant, so a tie alternates.
        w_grant_host = bus.host_req && (!w_poll_pending || owner_q == OWN_POLL);
        w_grant_poll = w_poll_pending && !w_grant_host;
        w_tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

        if (state_q != ST_IDLE) tmo_d = tmo_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_host || w_grant_poll) begin
                    state_d      = ST_ISSUE;
                    wr_en_d      = 1'b1;
                    tmo_d        = '0;
                    owner_d      = w_grant_host ? OWN_HOST : OWN_POLL;
                    wr_cmd_d     = w_grant_host ? bus.host_cmd : POLL_CMD;
                    host_ack_d   = w_grant_host;
                    w_poll_clear = w_grant_poll;
`ifdef N64_POLL_RETRY_EN
                    retry_d      = 1'b0;
`endif
                end
            end
            ST_ISSUE: begin
                if (bus.wr_busy) state_d = ST_WAIT_WR;
                else             wr_en_d = 1'b1;
            end
            ST_WAIT_WR: begin
                if (bus.wr_done) begin
                    rd_start_d = 1'b1;
                    state_d    = ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (bus.rd_done) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_POLL) begin
                        buttons_d       = bus.rd_data;
                        buttons_valid_d = 1'b1;
                    end else begin
                        resp_data_d     = bus.rd_data;
                        resp_valid_d    = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A response arriving on the timeout cycle still completes normally.
        if (state_q != ST_IDLE && w_tmo_hit && !(state_q == ST_WAIT_RD && bus.rd_done)) begin
            wr_en_d    = 1'b0;
            rd_start_d = 1'b0;
`ifdef N64_POLL_RETRY_EN
            if (owner_q == OWN_POLL && !retry_q) begin
                retry_d = 1'b1;
                tmo_d   = '0;
                state_d = ST_ISSUE;
                wr_en_d = 1'b1;
            end else begin
                timeout_err_d = 1'b1;
                state_d       = ST_IDLE;
            end
`else
            timeout_err_d = 1'b1;
            state_d       = ST_IDLE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_POLL;
            tmo_q           <= '0;
            wr_cmd_q        <= '0;
            wr_en_q         <= 1'b0;
            host_ack_q      <= 1'b0;
            rd_start_q      <= 1'b0;
            buttons_q       <= '0;
            buttons_valid_q <= 1'b0;
            resp_data_q     <= '0;
            resp_valid_q    <= 1'b0;
            timeout_err_q   <= 1'b0;
`ifdef N64_POLL_RETRY_EN
            retry_q         <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            tmo_q           <= tmo_d;
            wr_cmd_q        <= wr_cmd_d;
            wr_en_q         <= wr_en_d;
            host_ack_q      <= host_ack_d;
            rd_start_q      <= rd_start_d;
            buttons_q       <= buttons_d;
            buttons_valid_q <= buttons_valid_d;
            resp_data_q     <= resp_data_d;
            resp_valid_q    <= resp_valid_d;
            timeout_err_q   <= timeout_err_d;
`ifdef N64_POLL_RETRY_EN
            retry_q         <= retry_d;
`endif
        end
    end

    assign bus.wr_en         = wr_en_q;
    assign bus.wr_cmd        = wr_cmd_q;
    assign bus.host_ack      = host_ack_q;
    assign bus.rd_start      = rd_start_q;
    assign bus.buttons       = buttons_q;
    assign bus.buttons_valid = buttons_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.timeout_err   = timeout_err_q;
    assign bus.busy          = (state_q != ST_IDLE);

endmodule : n64_poll_ctrl
`default_nettype wire

// File: tb/tb_n64_poll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_n64_poll_ctrl
// Description : Directed bench with writer/reader models; N64_POLL_RETRY_EN
//               selects the retry variant of the timeout step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n64_poll_ctrl;
    import n64_pkg::*;

    localparam int P = 100;
    localparam int T = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    n64_poll_ctrl_if bus();

    n64_poll_ctrl #(.POLL_PERIOD(P), .TIMEOUT_CYC(T), .POLL_CMD(8'h01)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, rel0 = 0;
    int n_ack = 0, n_btn = 0, n_resp = 0, n_tmo = 0, n_rdstart = 0;
    int t_ack = 0, t_btn = 0, t_resp = 0, t_tmo = 0, t_plast = 0, t_pprev = 0;
    logic        prev_en  = 1'b0;
    logic [31:0] btn_word = 32'h8000_1234;
    logic [7:0]  cap_cmd  = 8'h00;
    int          hang_cnt = 0;
    int          snap_rd, snap_tmo;

    // Event monitor: cyc equals the edge number; samples 1 time unit after it.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.host_ack)      begin n_ack++;  t_ack  = cyc; end
            if (bus.buttons_valid) begin n_btn++;  t_btn  = cyc; end
            if (bus.resp_valid)    begin n_resp++; t_resp = cyc; end
            if (bus.timeout_err)   begin n_tmo++;  t_tmo  = cyc; end
            if (bus.rd_start)      n_rdstart++;
            if (bus.wr_en && !prev_en && bus.wr_cmd == 8'h01) begin
                t_pprev = t_plast;
                t_plast = cyc;
            end
            prev_en = bus.wr_en;
        end
    end

    // Writer model: busy three cycles after seeing wr_en, then a done pulse.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.wr_busy = 1'b0;
        bus.wr_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.wr_done = 1'b0;
            if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) begin
                    bus.wr_busy = 1'b0;
                    bus.wr_done = 1'b1;
                end
            end else if (bus.wr_en && !bus.wr_busy) begin
                bus.wr_busy = 1'b1;
                wcnt        = 3;
                cap_cmd     = bus.wr_cmd;
            end
        end
    end

    // Reader model: answers two cycles after rd_start unless told to hang.
    initial begin
        int rcnt;
        rcnt = 0;
        bus.rd_done = 1'b0;
        bus.rd_data = '0;
        forever begin
            @(negedge clk);
            bus.rd_done = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    bus.rd_done = 1'b1;
                    bus.rd_data = (cap_cmd == 8'h01) ? btn_word : {8'hC0, 16'h0000, cap_cmd};
                end
            end else if (bus.rd_start) begin
                if (hang_cnt > 0) hang_cnt--;
                else              rcnt = 2;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        while ((cyc - rel0) < c) @(negedge clk);
    endtask

    task automatic wait_ack(input string tag, input int limit);
        int snap, k;
        snap = n_ack;
        k    = 0;
        while (n_ack == snap && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(n_ack > snap), 32'd1);
    endtask

    task automatic check_reset(input string ph);
        check({ph, "_wr_en"},         32'(bus.wr_en),         32'd0);
        check({ph, "_wr_cmd"},        32'(bus.wr_cmd),        32'd0);
        check({ph, "_host_ack"},      32'(bus.host_ack),      32'd0);
        check({ph, "_rd_start"},      32'(bus.rd_start),      32'd0);
        check({ph, "_buttons"},       bus.buttons,            32'd0);
        check({ph, "_buttons_valid"}, 32'(bus.buttons_valid), 32'd0);
        check({ph, "_resp_data"},     bus.resp_data,          32'd0);
        check({ph, "_resp_valid"},    32'(bus.resp_valid),    32'd0);
        check({ph, "_timeout_err"},   32'(bus.timeout_err),   32'd0);
        check({ph, "_busy"},          32'(bus.busy),          32'd0);
    endtask

    initial begin
        bus.host_req = 1'b0;
        bus.host_cmd = 8'h00;
        rst_n        = 1'b0;
        repeat (4) @(negedge clk);
        check_reset("rst0");
        rst_n = 1'b1;
        rel0  = cyc;

        // Tie right after reset: pending appears after edge 100, host wins edge 101.
        goto(100);
        check("idle_before_tie", 32'(bus.busy), 32'd0);
        bus.host_cmd = N64_CMD_STATUS;
        bus.host_req = 1'b1;
        wait_ack("tie1_ack", 40);
        bus.host_req = 1'b0;
        goto(140);
        check("tie1_ack_cycle",  32'(t_ack - rel0), 32'd101);
        check("tie1_resp_cycle", 32'(t_resp - rel0), 32'd108);
        check("tie1_btn_cycle",  32'(t_btn - rel0), 32'd116);
        check("tie1_resp_data",  bus.resp_data, 32'hC000_0000);
        check("tie1_buttons",    bus.buttons, 32'h8000_1234);
        check("tie1_poll_cmd",   32'(cap_cmd), 32'h01);

        // Host-only grant, then a tie with last grant host: poll goes first.
        goto(150);
        bus.host_cmd = N64_CMD_RESET;
        bus.host_req = 1'b1;
        wait_ack("host_ff_ack", 40);
        bus.host_req = 1'b0;
        goto(190);
        check("host_ff_resp", bus.resp_data, 32'hC000_00FF);
        goto(200);
        bus.host_cmd = N64_CMD_STATUS;
        bus.host_req = 1'b1;
        wait_ack("tie2_ack", 40);
        bus.host_req = 1'b0;
        goto(240);
        check("tie2_poll_grant", 32'(t_plast - rel0), 32'd201);
        check("tie2_ack_cycle",  32'(t_ack - rel0), 32'd209);
        check("tie2_order",      32'(t_btn < t_resp), 32'd1);
        check("tie2_n_resp",     32'(n_resp), 32'd3);

        // Free-running polls every P cycles.
        goto(420);
        check("period_interval", 32'(t_plast - t_pprev), 32'd100);
        check("period_grant",    32'(t_plast - rel0), 32'd401);
        check("period_n_btn",    32'(n_btn), 32'd4);
        check("period_buttons",  bus.buttons, 32'h8000_1234);

        // Reader hangs on the poll granted at edge 501.
        hang_cnt = 1;
`ifdef N64_POLL_RETRY_EN
        btn_word = 32'hA5A5_0000;
        goto(570);
        check("retry_no_tmo",   32'(n_tmo), 32'd0);
        check("retry_reissue",  32'(t_plast - rel0), 32'd551);
        check("retry_buttons",  bus.buttons, 32'hA5A5_0000);
        check("retry_n_btn",    32'(n_btn), 32'd5);
        btn_word = 32'h8000_1234;
`else
        goto(570);
        check("tmo_count",   32'(n_tmo), 32'd1);
        check("tmo_latency", 32'(t_tmo - t_plast), 32'd50);
        check("tmo_busy",    32'(bus.busy), 32'd0);
        check("tmo_buttons", bus.buttons, 32'h8000_1234);
        check("tmo_n_btn",   32'(n_btn), 32'd4);
`endif

        // Reset while waiting on the reader of the poll granted at edge 601.
        hang_cnt = 1;
        goto(606);
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst_n    = 1'b0;
        snap_rd  = n_rdstart;
        snap_tmo = n_tmo;
        repeat (3) @(negedge clk);
        check_reset("rst1");
        rst_n = 1'b1;
        rel0  = cyc;
        goto(100);
        check("rst1_wr_en_100", 32'(bus.wr_en), 32'd0);
        check("rst1_rdstart",   32'(n_rdstart - snap_rd), 32'd0);
        goto(101);
        check("rst1_wr_en_101", 32'(bus.wr_en), 32'd1);
        check("rst1_wr_cmd",    32'(bus.wr_cmd), 32'h01);
        goto(130);
        check("rst1_no_tmo",    32'(n_tmo - snap_tmo), 32'd0);
        check("rst1_buttons",   bus.buttons, 32'h8000_1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_n64_poll_ctrl
`default_nettype wire
